// File: rtl/simon_seq_if.sv
// Player-side signal bundle for the simon_seq memory game.
// The game core takes the slave modport; whatever drives the switches
// and reads the LEDs (board top or bench) takes the master modport.
interface simon_seq_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64
) ();
    localparam int SW = $clog2(DEPTH + 1);

    logic             restart;
    logic             level;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] pattern_leds;
    logic [2:0]       mode_leds;
    logic [SW-1:0]    score;
    logic [SW-1:0]    hiscore;

    modport master (
        output restart, level, pattern,
        input  pattern_leds, mode_leds, score, hiscore
    );

    modport slave (
        input  restart, level, pattern,
        output pattern_leds, mode_leds, score, hiscore
    );
endinterface

// File: rtl/simon_seq.sv
// simon_seq: "Simon" style memory game.
// The player adds one pattern per round, the sequence is played back,
// then the player must repeat the whole sequence from the start.
// Optional macro SIMON_SEQ_HISCORE_EN keeps a best-score register;
// without it hiscore is tied to zero.
module simon_seq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64
) (
    input  logic       pclk,
    input  logic       rst,
    simon_seq_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // State encodings double as the mode_leds codes.
    typedef enum logic [2:0] {
        S_INPUT    = 3'b001,
        S_PLAYBACK = 3'b010,
        S_REPEAT   = 3'b100,
        S_DONE     = 3'b111,
        S_WIN      = 3'b110
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    len_q, len_d;
    logic [SW-1:0]    score_q, score_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    idx_wrap;
    logic             level_q, level_d;
    logic             pat_ok;
    logic             idx_last;
    logic             mem_we;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next-state logic; restart is applied last so it overrides everything.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        score_d  = score_q;
        level_d  = level_q;
        mem_we   = 1'b0;
        // Difficulty is only sampled before the first entry of a game.
        if (state_q == S_INPUT && len_q == '0)
            level_d = bus.level;
        // Validity uses the level sampled on this same edge.
        pat_ok   = level_d ? (|bus.pattern) : $onehot(bus.pattern);
        idx_last = (SW'(idx_q) == len_q - SW'(1));
        idx_wrap = idx_last ? '0 : idx_q + IW'(1);

        case (state_q)
            S_INPUT: begin
                if (pat_ok) begin
                    mem_we  = 1'b1;
                    len_d   = len_q + SW'(1);
                    idx_d   = '0;
                    state_d = S_PLAYBACK;
                end
            end
            S_PLAYBACK: begin
                idx_d = idx_wrap;
                if (idx_last)
                    state_d = S_REPEAT;
            end
            S_REPEAT: begin
                if (bus.pattern == mem_q[idx_q]) begin
                    idx_d = idx_wrap;
                    if (idx_last) begin
                        score_d = score_q + SW'(1);
                        state_d = (len_q == SW'(DEPTH)) ? S_WIN : S_INPUT;
                    end
                end else begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE, S_WIN: idx_d = idx_wrap;
            default:       state_d = S_INPUT;
        endcase

        if (bus.restart) begin
            state_d = S_INPUT;
            len_d   = '0;
            idx_d   = '0;
            score_d = '0;
            mem_we  = 1'b0;
        end
    end

    // Control/state registers, async active-low reset.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INPUT;
            len_q   <= '0;
            idx_q   <= '0;
            score_q <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            level_q <= level_d;
        end
    end

    // Sequence memory; never cleared, entries beyond len are ignored.
    always_ff @(posedge pclk) begin
        if (mem_we)
            mem_q[len_q[IW-1:0]] <= bus.pattern;
    end

`ifdef SIMON_SEQ_HISCORE_EN
    logic [SW-1:0] hiscore_q, hiscore_d;

    // Best score tracks the new score on the same edge it is exceeded.
    always_comb begin
        hiscore_d = (score_d > hiscore_q) ? score_d : hiscore_q;
    end

    // Best-score register; only rst clears it, restart does not.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) hiscore_q <= '0;
        else      hiscore_q <= hiscore_d;
    end

    assign bus.hiscore = hiscore_q;
`else
    assign bus.hiscore = '0;
`endif

    // Switches are echoed while the player is entering; stored data otherwise.
    assign bus.pattern_leds = (state_q == S_INPUT || state_q == S_REPEAT)
                              ? bus.pattern : mem_q[idx_q];
    assign bus.mode_leds    = state_q;
    assign bus.score        = score_q;
endmodule

// File: tb/tb_simon_seq.sv
// Bench for simon_seq: two instances (DEPTH=64 and DEPTH=2) checked every
// cycle against a sequence-level game model, plus directed literal checks.
module tb_simon_seq;
    localparam logic [2:0] M_IN = 3'b001, M_PB = 3'b010, M_RP = 3'b100,
                           M_DN = 3'b111, M_WN = 3'b110;

    logic pclk, rst;
    simon_seq_if #(.WIDTH(4), .DEPTH(64)) bus_a ();
    simon_seq_if #(.WIDTH(4), .DEPTH(2))  bus_b ();

    simon_seq #(.WIDTH(4), .DEPTH(64)) dut_a (.pclk(pclk), .rst(rst), .bus(bus_a));
    simon_seq #(.WIDTH(4), .DEPTH(2))  dut_b (.pclk(pclk), .rst(rst), .bus(bus_b));

    logic       in_rs [2];
    logic       in_lv [2];
    logic [3:0] in_pat [2];

    assign bus_a.restart = in_rs[0];
    assign bus_a.level   = in_lv[0];
    assign bus_a.pattern = in_pat[0];
    assign bus_b.restart = in_rs[1];
    assign bus_b.level   = in_lv[1];
    assign bus_b.pattern = in_pat[1];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Game model: stored sequence, cursor, phase, scores.
    logic [2:0] m_mode [2];
    logic [3:0] m_mem [2][64];
    int         m_len [2];
    int         m_pos [2];
    int         m_score [2];
    int         m_hi [2];
    bit         m_lvl [2];
    int         m_dep [2];

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic mreset(int k);
        m_mode[k] = M_IN; m_len[k] = 0; m_pos[k] = 0;
        m_score[k] = 0; m_hi[k] = 0; m_lvl[k] = 1'b0;
    endtask

    task automatic mstep(int k, bit rs, bit lv, logic [3:0] p);
        bit ok;
        if (rs) begin
            m_mode[k] = M_IN; m_len[k] = 0; m_pos[k] = 0; m_score[k] = 0;
        end else begin
            case (m_mode[k])
                M_IN: begin
                    if (m_len[k] == 0) m_lvl[k] = lv;
                    ok = m_lvl[k] ? (p != 0) : ($countones(p) == 1);
                    if (ok) begin
                        m_mem[k][m_len[k]] = p;
                        m_len[k]++;
                        m_pos[k] = 0;
                        m_mode[k] = M_PB;
                    end
                end
                M_PB: begin
                    if (m_pos[k] == m_len[k] - 1) begin
                        m_pos[k] = 0; m_mode[k] = M_RP;
                    end else m_pos[k]++;
                end
                M_RP: begin
                    if (p != m_mem[k][m_pos[k]]) begin
                        m_pos[k] = 0; m_mode[k] = M_DN;
                    end else if (m_pos[k] < m_len[k] - 1) begin
                        m_pos[k]++;
                    end else begin
                        m_score[k]++;
`ifdef SIMON_SEQ_HISCORE_EN
                        if (m_score[k] > m_hi[k]) m_hi[k] = m_score[k];
`endif
                        m_pos[k] = 0;
                        m_mode[k] = (m_len[k] == m_dep[k]) ? M_WN : M_IN;
                    end
                end
                default: m_pos[k] = (m_pos[k] == m_len[k] - 1) ? 0 : m_pos[k] + 1;
            endcase
        end
    endtask

    task automatic check(int k, logic [2:0] mode, logic [3:0] leds,
                         logic [15:0] sc, logic [15:0] hs);
        logic [3:0] el;
        el = (m_mode[k] == M_IN || m_mode[k] == M_RP) ? in_pat[k] : m_mem[k][m_pos[k]];
        vectors++;
        if (mode !== m_mode[k] || leds !== el || sc !== 16'(m_score[k]) || hs !== 16'(m_hi[k])) begin
            miscompares++;
            $display("FAIL model dut%0d t=%0t: mode %b leds %b score %0d hi %0d, need mode %b leds %b score %0d hi %0d",
                     k, $time, mode, leds, sc, hs, m_mode[k], el, m_score[k], m_hi[k]);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge pclk) begin
        if (chk_en) begin
            check(0, bus_a.mode_leds, bus_a.pattern_leds, 16'(bus_a.score), 16'(bus_a.hiscore));
            check(1, bus_b.mode_leds, bus_b.pattern_leds, 16'(bus_b.score), 16'(bus_b.hiscore));
        end
    end

    task automatic lit(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        if (rst) for (int k = 0; k < 2; k++) mstep(k, in_rs[k], in_lv[k], in_pat[k]);
        #2;
    endtask

    // Enter a fresh valid pattern, wait through playback, repeat the sequence.
    task automatic auto_round(int k);
        int n;
        in_rs[k] = 1'b0;
        in_lv[k] = 1'b1;
        in_pat[k] = 4'($urandom_range(1, 15));
        cyc();
        n = 0;
        while (m_mode[k] != M_RP && n < 300) begin cyc(); n++; end
        if (n >= 300) begin
            miscompares++;
            $display("FAIL auto_round dut%0d: REPEAT not reached", k);
        end
        for (int i = 0; i < m_len[k]; i++) begin
            in_pat[k] = m_mem[k][i];
            cyc();
        end
    endtask

    initial begin
        int hs_exp3, hs_exp2, hs_exp64;
`ifdef SIMON_SEQ_HISCORE_EN
        hs_exp3 = 3; hs_exp2 = 2; hs_exp64 = 64;
`else
        hs_exp3 = 0; hs_exp2 = 0; hs_exp64 = 0;
`endif
        m_dep[0] = 64; m_dep[1] = 2;
        for (int k = 0; k < 2; k++) begin
            in_rs[k] = 1'b0; in_lv[k] = 1'b0; in_pat[k] = 4'b0000; mreset(k);
        end
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(); cyc();
        lit("reset mode", int'(bus_a.mode_leds), 1);
        lit("reset score", int'(bus_a.score), 0);
        rst = 1'b1;

        // Basic game on the DEPTH=64 instance.
        in_pat[0] = 4'b0001; cyc();
        lit("first entry mode", int'(bus_a.mode_leds), 2);
        lit("first entry leds", int'(bus_a.pattern_leds), 1);
        cyc();
        lit("playback done mode", int'(bus_a.mode_leds), 4);
        cyc();
        lit("round1 mode", int'(bus_a.mode_leds), 1);
        lit("round1 score", int'(bus_a.score), 1);
        in_lv[0] = 1'b1; in_pat[0] = 4'b1010; cyc();
        lit("level latched", int'(bus_a.mode_leds), 1);
        in_pat[0] = 4'b1000; cyc();
        lit("second entry mode", int'(bus_a.mode_leds), 2);
        lit("playback[0]", int'(bus_a.pattern_leds), 4'b0001);
        cyc();
        lit("playback[1]", int'(bus_a.pattern_leds), 4'b1000);
        cyc();
        lit("repeat mode", int'(bus_a.mode_leds), 4);
        in_pat[0] = 4'b0001; cyc();
        lit("first guess mode", int'(bus_a.mode_leds), 4);
        in_pat[0] = 4'b0100; cyc();
        lit("miss mode", int'(bus_a.mode_leds), 7);
        lit("miss score", int'(bus_a.score), 1);
        lit("done leds0", int'(bus_a.pattern_leds), 4'b0001);
        cyc();
        lit("done leds1", int'(bus_a.pattern_leds), 4'b1000);
        cyc();
        lit("done leds2", int'(bus_a.pattern_leds), 4'b0001);
        lit("done mode", int'(bus_a.mode_leds), 7);

        // Full game on the DEPTH=2 instance.
        in_lv[1] = 1'b1; in_pat[1] = 4'b0011; cyc(); cyc();
        cyc();
        lit("d2 round1 score", int'(bus_b.score), 1);
        in_pat[1] = 4'b1100; cyc(); cyc(); cyc();
        lit("d2 repeat", int'(bus_b.mode_leds), 4);
        in_pat[1] = 4'b0011; cyc();
        in_pat[1] = 4'b1100; cyc();
        lit("d2 win mode", int'(bus_b.mode_leds), 6);
        lit("d2 win score", int'(bus_b.score), 2);
        lit("d2 hiscore", int'(bus_b.hiscore), hs_exp2);
        in_pat[1] = 4'b0000;

        // Restart mid-REPEAT after three rounds.
        in_rs[0] = 1'b1; cyc(); in_rs[0] = 1'b0;
        for (int r = 0; r < 3; r++) auto_round(0);
        lit("three rounds", int'(bus_a.score), 3);
        in_pat[0] = 4'b0010; cyc(); cyc(); cyc(); cyc(); cyc();
        lit("round4 repeat", int'(bus_a.mode_leds), 4);
        in_pat[0] = m_mem[0][0]; cyc();
        in_rs[0] = 1'b1; cyc(); in_rs[0] = 1'b0;
        lit("restart mode", int'(bus_a.mode_leds), 1);
        lit("restart score", int'(bus_a.score), 0);
        lit("restart hiscore", int'(bus_a.hiscore), hs_exp3);

        // Async reset in the middle of PLAYBACK.
        auto_round(0);
        in_pat[0] = 4'b0100; cyc();
        lit("pre-reset playback", int'(bus_a.mode_leds), 2);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) mreset(k);
        lit("async mode", int'(bus_a.mode_leds), 1);
        lit("async score", int'(bus_a.score), 0);
        lit("async hiscore", int'(bus_a.hiscore), 0);
        cyc();
        rst = 1'b1;

        // Win the 64-deep game: len reaches DEPTH, score reaches 64.
        for (int r = 0; r < 64; r++) auto_round(0);
        lit("d64 win mode", int'(bus_a.mode_leds), 6);
        lit("d64 score", int'(bus_a.score), 64);
        lit("d64 hiscore", int'(bus_a.hiscore), hs_exp64);
        cyc(); cyc();

        // Randomised play, biased toward correct guesses.
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < 2; k++) begin
                in_rs[k] = ($urandom_range(0, 299) == 0) ||
                           ((m_mode[k] == M_DN || m_mode[k] == M_WN) && $urandom_range(0, 7) == 0);
                in_lv[k] = 1'($urandom_range(0, 1));
                if (m_mode[k] == M_RP && $urandom_range(0, 49) != 0)
                    in_pat[k] = m_mem[k][m_pos[k]];
                else if ($urandom_range(0, 1) == 1)
                    in_pat[k] = 4'(1 << $urandom_range(0, 3));
                else
                    in_pat[k] = 4'($urandom_range(0, 15));
            end
            cyc();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
